// File: rtl/backend_muxs.sv
// Combat backend for the two-fighter game: detects new key presses, resolves one
// turn per press against a fixed CPU pattern and holds both health values.
module backend_muxs (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyboard_input,
  output logic [6:0] p1_health_out,
  output logic [6:0] cpu_health_out
);

  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_ATTACK = 2'd1,
    ACT_BLOCK  = 2'd2,
    ACT_HEAL   = 2'd3
  } action_t;

  typedef enum logic {
    ST_PLAYING = 1'b0,
    ST_KO      = 1'b1
  } game_state_t;

  localparam logic [6:0] START_HP = 7'd100;
  localparam logic [6:0] DAMAGE   = 7'd10;
  localparam logic [6:0] HEAL_AMT = 7'd5;
  localparam logic [6:0] HP_CAP   = 7'd100;

  function automatic action_t decode_key(input logic [3:0] code);
    action_t act;
    case (code)
      4'd1:    act = ACT_ATTACK;
      4'd2:    act = ACT_BLOCK;
      4'd3:    act = ACT_HEAL;
      default: act = ACT_IDLE;
    endcase
    return act;
  endfunction

  function automatic action_t cpu_pattern(input logic [1:0] idx);
    action_t act;
    case (idx)
      2'd0:    act = ACT_ATTACK;
      2'd1:    act = ACT_BLOCK;
      2'd2:    act = ACT_ATTACK;
      2'd3:    act = ACT_HEAL;
      default: act = ACT_IDLE;
    endcase
    return act;
  endfunction

  function automatic logic [6:0] take_hit(input logic [6:0] hp, input logic hit);
    logic [6:0] res;
    if (!hit) begin
      res = hp;
    end else if (hp >= DAMAGE) begin
      res = hp - DAMAGE;
    end else begin
      res = 7'd0;
    end
    return res;
  endfunction

  // A knocked-out fighter (post-damage 0) cannot heal back into the game.
  function automatic logic [6:0] take_heal(input logic [6:0] hp, input logic heal);
    logic [7:0] sum;
    logic [6:0] res;
    sum = {1'b0, hp} + {1'b0, HEAL_AMT};
    if (!heal || hp == 7'd0) begin
      res = hp;
    end else if (sum > {1'b0, HP_CAP}) begin
      res = HP_CAP;
    end else begin
      res = sum[6:0];
    end
    return res;
  endfunction

  logic [3:0]  key_q;
  logic [1:0]  cpu_idx;
  logic [6:0]  p1_hp;
  logic [6:0]  cpu_hp;
  game_state_t state;

  action_t    p1_act;
  action_t    cpu_act;
  logic       press;
  logic       p1_hit;
  logic       cpu_hit;
  logic [6:0] p1_post;
  logic [6:0] cpu_post;
  logic [6:0] p1_next;
  logic [6:0] cpu_next;
  logic       ko_next;

  // Press detection and simultaneous turn resolution for both fighters.
  always_comb begin
    p1_act   = decode_key(keyboard_input);
    cpu_act  = cpu_pattern(cpu_idx);
    press    = 1'b0;
    if (state == ST_PLAYING && p1_act != ACT_IDLE && keyboard_input != key_q) begin
      press = 1'b1;
    end else begin
      press = 1'b0;
    end
    p1_hit   = (cpu_act == ACT_ATTACK) && (p1_act != ACT_BLOCK);
    cpu_hit  = (p1_act == ACT_ATTACK) && (cpu_act != ACT_BLOCK);
    p1_post  = take_hit(p1_hp, p1_hit);
    cpu_post = take_hit(cpu_hp, cpu_hit);
    p1_next  = take_heal(p1_post, p1_act == ACT_HEAL);
    cpu_next = take_heal(cpu_post, cpu_act == ACT_HEAL);
    ko_next  = (p1_next == 7'd0) || (cpu_next == 7'd0);
  end

  // Game state: key history, CPU pattern position, health and knockout latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q   <= 4'd0;
      cpu_idx <= 2'd0;
      p1_hp   <= START_HP;
      cpu_hp  <= START_HP;
      state   <= ST_PLAYING;
    end else begin
      key_q <= keyboard_input;
      if (press) begin
        p1_hp   <= p1_next;
        cpu_hp  <= cpu_next;
        cpu_idx <= cpu_idx + 2'd1;
        if (ko_next) begin
          state <= ST_KO;
        end else begin
          state <= ST_PLAYING;
        end
      end else begin
        p1_hp   <= p1_hp;
        cpu_hp  <= cpu_hp;
        cpu_idx <= cpu_idx;
        state   <= state;
      end
    end
  end

  assign p1_health_out  = p1_hp;
  assign cpu_health_out = cpu_hp;

endmodule

// File: tb/tb_backend_muxs.sv
// Self-checking bench for backend_muxs: directed scenarios plus randomized key
// streams, compared against a turn-level reference model.
module tb_backend_muxs;

  logic       clk;
  logic       reset;
  logic [3:0] keyboard_input;
  logic [6:0] p1_health_out;
  logic [6:0] cpu_health_out;

  int n_checks;
  int n_errors;

  // Reference model state: plain integers, CPU pattern as a lookup table.
  int m_p1, m_cpu, m_idx, m_prev;
  bit m_over;
  int cpu_plan[4] = '{1, 2, 1, 3};

  backend_muxs dut (
    .clk            (clk),
    .reset          (reset),
    .keyboard_input (keyboard_input),
    .p1_health_out  (p1_health_out),
    .cpu_health_out (cpu_health_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = 100; m_cpu = 100; m_idx = 0; m_prev = 0; m_over = 0;
  endtask

  task automatic model_step(input int k);
    int ca, d1, d2;
    if (k >= 1 && k <= 3 && k != m_prev && !m_over) begin
      ca = cpu_plan[m_idx];
      d1 = (ca == 1 && k != 2) ? 10 : 0;
      d2 = (k == 1 && ca != 2) ? 10 : 0;
      m_p1  = (m_p1 - d1 < 0) ? 0 : m_p1 - d1;
      m_cpu = (m_cpu - d2 < 0) ? 0 : m_cpu - d2;
      if (k == 3 && m_p1 > 0)   m_p1  = (m_p1 + 5 > 100) ? 100 : m_p1 + 5;
      if (ca == 3 && m_cpu > 0) m_cpu = (m_cpu + 5 > 100) ? 100 : m_cpu + 5;
      m_idx = (m_idx + 1) % 4;
      if (m_p1 == 0 || m_cpu == 0) m_over = 1;
    end
    m_prev = k;
  endtask

  task automatic check_hp(input string tag, input int p1, input int cpu);
    check({tag, "_p1"}, {1'b0, p1_health_out}, 8'(p1));
    check({tag, "_cpu"}, {1'b0, cpu_health_out}, 8'(cpu));
  endtask

  // Drive one code for one clock, then compare against the model.
  task automatic apply(input logic [3:0] k);
    keyboard_input = k;
    @(posedge clk);
    #1;
    model_step(int'(k));
    check_hp("model", m_p1, m_cpu);
  endtask

  // Mid-cycle reset pulse; outputs must recover before any clock edge.
  task automatic pulse_reset(input logic [3:0] hold);
    #2;
    reset = 1'b0;
    keyboard_input = hold;
    #1;
    check_hp("async_rst", 100, 100);
    model_reset();
    @(posedge clk);
    #1;
    check_hp("rst_held", 100, 100);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] seq[13] = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    keyboard_input = 4'd0;
    model_reset();

    for (int i = 0; i < 6; i++) begin
      keyboard_input = 4'(1 + i % 3);
      @(posedge clk);
      #1;
      check_hp("in_reset", 100, 100);
    end
    keyboard_input = 4'd0;
    reset = 1'b1;

    for (int i = 0; i < 5; i++) apply(4'd1);
    check_hp("hold_attack", 90, 90);

    pulse_reset(4'd0);
    foreach (seq[i]) apply(seq[i]);
    check_hp("sequence", 80, 75);

    pulse_reset(4'd0);
    apply(4'd3);
    check_hp("heal_first", 95, 100);
    apply(4'd0);
    apply(4'd3);
    check_hp("heal_cap", 100, 100);

    pulse_reset(4'd0);
    for (int t = 1; t <= 16; t++) begin
      apply(4'd1);
      if (t == 12) check_hp("turn12", 40, 25);
      if (t == 15) check_hp("turn15", 20, 5);
      apply(4'd0);
    end
    check_hp("ko_turn16", 20, 0);
    for (int i = 0; i < 3; i++) begin
      apply(4'd1);
      apply(4'd3);
      apply(4'd0);
    end
    check_hp("ko_frozen", 20, 0);

    pulse_reset(4'd0);
    for (int k = 4; k < 16; k++) apply(4'(k));
    check_hp("codes_4_15", 100, 100);
    apply(4'd1);
    apply(4'd2);
    apply(4'd1);
    check_hp("direct_1_2", 80, 80);

    pulse_reset(4'd1);
    apply(4'd1);
    check_hp("held_at_release", 90, 90);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59, 0) == 0) begin
        pulse_reset(4'($urandom_range(3, 0)));
      end else if ($urandom_range(9, 0) == 0) begin
        apply(4'($urandom_range(15, 0)));
      end else begin
        apply(4'($urandom_range(3, 0)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
